// File: rtl/ysyx_23060236_rd_arbiter.sv
// Read-channel arbiter: shares one AXI-like read master between the IFU and the LSU,
// with round-robin tie-break and a single transaction in flight.
module ysyx_23060236_rd_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [31:0] ifu_araddr,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  input  logic [31:0] lsu_araddr,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        v_io_master_arvalid,
  input  logic        v_io_master_arready,
  output logic [31:0] v_io_master_araddr,
  input  logic        v_io_master_rvalid,
  output logic        v_io_master_rready,
  input  logic [31:0] v_io_master_rdata,
  input  logic [1:0]  v_io_master_rresp
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] IFU_AR = 3'd1;
  localparam logic [2:0] LSU_AR = 3'd2;
  localparam logic [2:0] IFU_R  = 3'd3;
  localparam logic [2:0] LSU_R  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        last_lsu_q, last_lsu_d;
  logic        ifu_win, lsu_win;

  // On a tie the client that did not win last time gets the grant.
  always_comb begin
    ifu_win = ifu_arvalid && (!lsu_arvalid || last_lsu_q);
    lsu_win = lsu_arvalid && !ifu_win;
  end

  always_comb begin
    ifu_arready         = (state_q == IDLE) && reset && ifu_win;
    lsu_arready         = (state_q == IDLE) && reset && lsu_win;
    v_io_master_arvalid = (state_q == IFU_AR) || (state_q == LSU_AR);
    v_io_master_araddr  = addr_q;
    ifu_rvalid          = (state_q == IFU_R) && v_io_master_rvalid;
    lsu_rvalid          = (state_q == LSU_R) && v_io_master_rvalid;
    v_io_master_rready  = 1'b0;
    if (state_q == IFU_R) begin
      v_io_master_rready = ifu_rready;
    end else if (state_q == LSU_R) begin
      v_io_master_rready = lsu_rready;
    end
    rdata = v_io_master_rdata;
    rresp = v_io_master_rresp;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_lsu_d = last_lsu_q;
    case (state_q)
      IDLE: begin
        if (ifu_arready) begin
          addr_d     = ifu_araddr;
          last_lsu_d = 1'b0;
          state_d    = IFU_AR;
        end else if (lsu_arready) begin
          addr_d     = lsu_araddr;
          last_lsu_d = 1'b1;
          state_d    = LSU_AR;
        end
      end
      IFU_AR: if (v_io_master_arready) state_d = IFU_R;
      LSU_AR: if (v_io_master_arready) state_d = LSU_R;
      IFU_R:  if (v_io_master_rvalid && ifu_rready) state_d = IDLE;
      LSU_R:  if (v_io_master_rvalid && lsu_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any in-flight request; nothing is delivered for it afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0;
      last_lsu_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_lsu_q <= last_lsu_d;
    end
  end

endmodule

// File: doc/ysyx_23060236_rd_arbiter.md
YSYX_23060236_RD_ARBITER -- requirements
Module: ysyx_23060236_rd_arbiter

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ifu_arvalid  input  1  IFU read request valid.
REQ-004 SHALL have port: ifu_arready  output  1  IFU request accepted this cycle.
REQ-005 SHALL have port: ifu_araddr  input  32  IFU read address.
REQ-006 SHALL have port: ifu_rvalid  output  1  read data valid to IFU.
REQ-007 SHALL have port: ifu_rready  input  1  IFU ready for read data.
REQ-008 SHALL have port: lsu_arvalid  input  1  LSU load request valid.
REQ-009 SHALL have port: lsu_arready  output  1  LSU request accepted this cycle.
REQ-010 SHALL have port: lsu_araddr  input  32  LSU load address.
REQ-011 SHALL have port: lsu_rvalid  output  1  read data valid to LSU.
REQ-012 SHALL have port: lsu_rready  input  1  LSU ready for read data.
REQ-013 SHALL have port: rdata  output  32  shared read data to both clients.
REQ-014 SHALL have port: rresp  output  2  shared read response to both clients.
REQ-015 SHALL have port: v_io_master_arvalid  output  1  request valid toward MMU.
REQ-016 SHALL have port: v_io_master_arready  input  1  MMU accepted request.
REQ-017 SHALL have port: v_io_master_araddr  output  32  granted virtual address toward MMU.
REQ-018 SHALL have port: v_io_master_rvalid  input  1  read data valid from memory side.
REQ-019 SHALL have port: v_io_master_rready  output  1  arbiter ready for read data.
REQ-020 SHALL have port: v_io_master_rdata  input  32  read data from memory side.
REQ-021 SHALL have port: v_io_master_rresp  input  2  read response from memory side.

Function
REQ-022 SHALL implement FSM states IDLE, IFU_AR, LSU_AR, IFU_R, LSU_R; one transaction outstanding at a time.
REQ-023 In IDLE, SHALL assert exactly one of ifu_arready/lsu_arready, combinationally, to the winning requester (valid high); both low if no request.
REQ-024 Tie (both valids high in IDLE): SHALL grant the client not granted last; last-grant register resets to IFU, so first tie goes to LSU.
REQ-025 On grant, SHALL latch winner address into a 32-bit register, update last-grant, and move to IFU_AR/LSU_AR next cycle.
REQ-026 In IFU_AR/LSU_AR: v_io_master_arvalid=1, v_io_master_araddr=latched address, held stable until v_io_master_arready=1; then to IFU_R/LSU_R.
REQ-027 v_io_master_arvalid SHALL be 0 in all other states; client arready SHALL be 0 outside IDLE.
REQ-028 In IFU_R: ifu_rvalid=v_io_master_rvalid, v_io_master_rready=ifu_rready; LSU_R symmetric with lsu_*; non-owner rvalid=0.
REQ-029 rdata/rresp SHALL pass v_io_master_rdata/rresp combinationally in all states; consumers qualify with their rvalid.
REQ-030 On rvalid&&rready in an R state, SHALL return to IDLE; new grant possible the following cycle (no back-to-back in same cycle).
REQ-031 In IDLE/AR states, v_io_master_rready=0 and any v_io_master_rvalid SHALL be ignored (not forwarded).
REQ-032 Error rresp (non-zero) SHALL be forwarded unchanged; FSM flow identical to OKAY.
REQ-033 Latency: accept at cycle T, v_io_master_arvalid high at T+1; earliest client rvalid T+2 (arready at T+1, rvalid at T+2).
REQ-034 Client dropping arvalid after acceptance SHALL NOT affect the latched transaction.

Reset
REQ-035 reset low SHALL immediately force IDLE, last-grant=IFU, latched address=0, all valid/ready outputs 0 (except combinational IDLE arready per REQ-023 once reset releases).
REQ-036 Reset mid-transaction SHALL abandon it: no rvalid delivered to any client for that request.

Verification
REQ-037 IFU only, addr 0x3000_0000, arready=1, rvalid one cycle later with rdata 0xDEAD_BEEF -> ifu_arready at T, master arvalid/araddr 0x3000_0000 at T+1, ifu_rvalid with 0xDEAD_BEEF at T+2, lsu_rvalid=0.
REQ-038 Both request after reset (IFU 0x100, LSU 0x200), then both again -> first master araddr 0x200, second 0x100.
REQ-039 v_io_master_arready held low 5 cycles in LSU_AR -> arvalid held, araddr stable 5 cycles, no client arready.
REQ-040 In LSU_R, lsu_rready low 3 cycles while rvalid high -> lsu_rvalid high 3 cycles, v_io_master_rready low, FSM stays in LSU_R.
REQ-041 reset asserted in IFU_R with rvalid pending -> outputs 0 same cycle, ifu_rvalid never asserted, IDLE after release.
REQ-042 rresp=2'b10 on IFU read -> ifu_rvalid with rresp 2'b10, FSM returns to IDLE.
